// File: rtl/dino_pkg.sv
// Shared constants for the obstacle engine: screen geometry defaults, FSM encodings, LFSR seed/taps.
package dino_pkg;
  localparam int SCREEN_W_DEF = 640;
  localparam int GROUND_Y_DEF = 400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic lfsr_fb(input logic [7:0] v);
    return ^(v & LFSR_TAPS);
  endfunction
endpackage

// File: rtl/obstacle_engine_if.sv
// Frame/pixel inputs and game-state outputs between the obstacle engine and its neighbours.
interface obstacle_engine_if;
  logic       i_game_tick;
  logic [9:0] i_hpos;
  logic [9:0] i_vpos;
  logic       i_collision;
  logic       i_restart;
  logic       o_color_obstacle;
  logic       o_game_over;
  logic       o_running;
  logic [3:0] o_speed;
  logic [7:0] o_passed;

  modport master (
    output i_game_tick, i_hpos, i_vpos, i_collision, i_restart,
    input  o_color_obstacle, o_game_over, o_running, o_speed, o_passed
  );

  modport slave (
    input  i_game_tick, i_hpos, i_vpos, i_collision, i_restart,
    output o_color_obstacle, o_game_over, o_running, o_speed, o_passed
  );
endinterface

// File: rtl/obstacle_engine_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used for spawn gap and height randomisation.
module lfsr8
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] o_value
);
  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= LFSR_SEED;
    else     r_q <= {r_q[6:0], lfsr_fb(r_q)};
  end

  assign o_value = r_q;
endmodule

// File: rtl/obstacle_engine.sv
// Obstacle spawn/scroll engine with IDLE/RUN/DEAD FSM and a zero-latency obstacle painter.
// Build option OBSTACLE_TALL_EN: each slot carries a height bit selecting double-height obstacles.
module obstacle_engine
  import dino_pkg::*;
#(
  parameter int NUM_OBS    = 2,
  parameter int OBS_W      = 16,
  parameter int OBS_H      = 32,
  parameter int GROUND_Y   = GROUND_Y_DEF,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int MIN_GAP    = 160,
  parameter int SPEED_INIT = 4,
  parameter int SPEED_MAX  = 12
) (
  input logic              clk,
  input logic              rst,
  obstacle_engine_if.slave bus
);
  localparam logic [9:0] TOP_SHORT = 10'(GROUND_Y - OBS_H);
`ifdef OBSTACLE_TALL_EN
  localparam logic [9:0] TOP_TALL  = 10'(GROUND_Y - 2*OBS_H);
`endif

  state_e                  r_state, w_state;
  logic [NUM_OBS-1:0][9:0] r_x, w_x, w_top;
  logic [NUM_OBS-1:0]      r_act, w_act;
`ifdef OBSTACLE_TALL_EN
  logic [NUM_OBS-1:0]      r_tall, w_tall;
`endif
  logic [3:0]              r_speed, w_speed;
  logic [7:0]              r_passed, w_passed;
  logic [8:0]              r_gap, w_gap;
  logic [2:0]              w_rm;
  logic                    w_found, w_init, w_color;
  logic [7:0]              w_lfsr;

  lfsr8 u_lfsr (.clk(clk), .rst(rst), .o_value(w_lfsr));

`ifndef OBSTACLE_TALL_EN
  logic w_unused_lfsr_msb;
  assign w_unused_lfsr_msb = w_lfsr[7];
`endif

  always_comb begin
    w_state  = r_state;
    w_x      = r_x;
    w_act    = r_act;
`ifdef OBSTACLE_TALL_EN
    w_tall   = r_tall;
`endif
    w_speed  = r_speed;
    w_passed = r_passed;
    w_gap    = r_gap;
    w_rm     = '0;
    w_found  = 1'b0;
    w_init   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DEAD: w_init = bus.i_restart;
      ST_RUN: begin
        if (bus.i_collision)      w_state = ST_DEAD;
        else if (bus.i_restart)   w_init  = 1'b1;
        else if (bus.i_game_tick) begin
          for (int i = 0; i < NUM_OBS; i++) begin
            if (r_act[i]) begin
              if (r_x[i] < {6'd0, r_speed}) begin
                w_act[i] = 1'b0;
                w_rm     = w_rm + 3'd1;
              end else begin
                w_x[i] = r_x[i] - {6'd0, r_speed};
              end
            end
          end
          // Spawn search sees slots freed above, so a removal can be refilled on the same tick
          if (r_gap <= {5'd0, r_speed}) begin
            w_gap = '0;
            for (int i = 0; i < NUM_OBS; i++) begin
              if (!w_found && !w_act[i]) begin
                w_found  = 1'b1;
                w_act[i] = 1'b1;
                w_x[i]   = 10'(SCREEN_W);
`ifdef OBSTACLE_TALL_EN
                w_tall[i] = w_lfsr[7];
`endif
                w_gap    = 9'(MIN_GAP) + {2'd0, w_lfsr[6:0]};
              end
            end
          end else begin
            w_gap = r_gap - {5'd0, r_speed};
          end
          w_passed = r_passed + {5'd0, w_rm};
          if (({1'b0, r_passed[3:0]} + {2'd0, w_rm}) > 5'd15 && r_speed < 4'(SPEED_MAX))
            w_speed = r_speed + 4'd1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
    if (w_init) begin
      w_state  = ST_RUN;
      w_x      = '0;
      w_act    = '0;
`ifdef OBSTACLE_TALL_EN
      w_tall   = '0;
`endif
      w_speed  = 4'(SPEED_INIT);
      w_passed = '0;
      w_gap    = '0;
    end
  end

  always_comb begin
    w_top   = '0;
    w_color = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
`ifdef OBSTACLE_TALL_EN
      w_top[i] = r_tall[i] ? TOP_TALL : TOP_SHORT;
`else
      w_top[i] = TOP_SHORT;
`endif
      if (r_act[i] && bus.i_hpos >= r_x[i] &&
          {1'b0, bus.i_hpos} < ({1'b0, r_x[i]} + 11'(OBS_W)) &&
          bus.i_vpos >= w_top[i] && bus.i_vpos < 10'(GROUND_Y))
        w_color = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_x      <= '0;
      r_act    <= '0;
`ifdef OBSTACLE_TALL_EN
      r_tall   <= '0;
`endif
      r_speed  <= 4'(SPEED_INIT);
      r_passed <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state;
      r_x      <= w_x;
      r_act    <= w_act;
`ifdef OBSTACLE_TALL_EN
      r_tall   <= w_tall;
`endif
      r_speed  <= w_speed;
      r_passed <= w_passed;
      r_gap    <= w_gap;
    end
  end

  assign bus.o_color_obstacle = w_color;
  assign bus.o_game_over      = (r_state == ST_DEAD);
  assign bus.o_running        = (r_state == ST_RUN);
  assign bus.o_speed          = r_speed;
  assign bus.o_passed         = r_passed;
endmodule

// File: tb/tb_obstacle_engine.sv
// Randomized bench for obstacle_engine checked against a frame-level behavioural model.
module tb_obstacle_engine;
  localparam int NOBS = 2;
  localparam int GY   = 400;
  localparam int OW   = 16;
  localparam int OH   = 32;
`ifdef OBSTACLE_TALL_EN
  localparam bit TALL = 1'b1;
`else
  localparam bit TALL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obstacle_engine_if bus();
  obstacle_engine #(.NUM_OBS(NOBS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0=idle 1=run 2=dead
  int         m_state;
  int         m_x    [NOBS];
  bit         m_act  [NOBS];
  bit         m_tall [NOBS];
  int         m_speed, m_passed, m_gap;
  logic [7:0] m_lfsr;

  function automatic int m_h(input int i);
    return (TALL && m_tall[i]) ? 2*OH : OH;
  endfunction

  function automatic bit m_color(input int h, input int v);
    for (int i = 0; i < NOBS; i++)
      if (m_act[i] && h >= m_x[i] && h < m_x[i] + OW && v >= GY - m_h(i) && v < GY) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_start();
    for (int i = 0; i < NOBS; i++) begin m_act[i] = 0; m_x[i] = 0; m_tall[i] = 0; end
    m_state = 1; m_speed = 4; m_passed = 0; m_gap = 0;
  endtask

  task automatic model_frame(input logic [7:0] lf);
    int s = m_speed;
    int rm = 0;
    bit got = 0;
    for (int i = 0; i < NOBS; i++)
      if (m_act[i]) begin
        if (m_x[i] < s) begin m_act[i] = 0; rm++; end
        else m_x[i] -= s;
      end
    if (m_gap <= s) begin
      m_gap = 0;
      for (int i = 0; i < NOBS; i++)
        if (!got && !m_act[i]) begin
          got = 1; m_act[i] = 1; m_x[i] = 640; m_tall[i] = lf[7];
          m_gap = 160 + int'(lf[6:0]);
        end
    end else m_gap -= s;
    if ((m_passed % 16) + rm >= 16 && m_speed < 12) m_speed++;
    m_passed = (m_passed + rm) % 256;
  endtask

  task automatic model_clk(input bit r, input bit tick, input bit coll, input bit rs);
    logic [7:0] lf;
    if (r) begin
      model_start(); m_state = 0; m_lfsr = 8'hA5;
      return;
    end
    lf = m_lfsr;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    if (m_state == 1) begin
      if (coll) m_state = 2;
      else if (rs) model_start();
      else if (tick) model_frame(lf);
    end else if (rs) model_start();
  endtask

  task automatic cyc(input int tick, input int coll, input int rs);
    bus.i_game_tick = (tick != 0);
    bus.i_collision = (coll != 0);
    bus.i_restart   = (rs != 0);
    @(posedge clk);
    model_clk(rst, tick != 0, coll != 0, rs != 0);
    @(negedge clk);
    bus.i_game_tick = 1'b0;
    bus.i_collision = 1'b0;
    bus.i_restart   = 1'b0;
  endtask

  // Status word: {running, game_over, speed[3:0], passed[7:0], colour}
  task automatic probe(input int h, input int v, output logic [14:0] act, output logic [14:0] exp);
    bus.i_hpos = 10'(h);
    bus.i_vpos = 10'(v);
    #1;
    act = {bus.o_running, bus.o_game_over, bus.o_speed, bus.o_passed, bus.o_color_obstacle};
    exp = {(m_state == 1), (m_state == 2), 4'(m_speed), 8'(m_passed), m_color(h, v)};
  endtask

  task automatic pick(output int h, output int v);
    int i = int'($urandom_range(NOBS-1, 0));
    if (m_act[i] && $urandom_range(3, 0) != 0) begin
      h = m_x[i] - 1 + int'($urandom_range(OW+1, 0));
      v = GY - m_h(i) - 1 + int'($urandom_range(m_h(i)+1, 0));
    end else begin
      h = int'($urandom_range(1023, 0));
      v = int'($urandom_range(479, 0));
    end
    if (h < 0) h = 0;
    if (h > 1023) h = 1023;
  endtask

  task automatic test_reset();
    logic [14:0] a, e, k;
    k = {2'b00, 4'd4, 8'd0, 1'b0};
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 1);
    probe(100, 380, a, e);
    n_cmp++; if (a !== k) begin n_bad++; $display("FAIL reset_state: dut=%h exp=%h", a, k); end
    rst = 1'b0;
    cyc(1, 0, 0);
    probe(640, 399, a, e);
    n_cmp++; if (a !== e || a[14] !== 1'b0) begin n_bad++; $display("FAIL idle_ignores_tick: dut=%h exp=%h", a, e); end
  endtask

  task automatic test_first_spawn();
    logic [14:0] a, e;
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    probe(640, 399, a, e);
    n_cmp++; if (a !== e || a[14] !== 1'b1 || a[0] !== 1'b1) begin n_bad++; $display("FAIL spawn_640: dut=%h exp=%h", a, e); end
    probe(639, 399, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b0) begin n_bad++; $display("FAIL spawn_639: dut=%h exp=%h", a, e); end
    cyc(1, 0, 0);
    probe(636, 368, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b1) begin n_bad++; $display("FAIL scroll_636: dut=%h exp=%h", a, e); end
    probe(652, 399, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b0) begin n_bad++; $display("FAIL scroll_652: dut=%h exp=%h", a, e); end
  endtask

  task automatic test_pixel_bounds();
    logic [14:0] a, e;
    int t;
    for (t = 0; t < 400 && !(m_act[0] && m_x[0] == 100); t++) cyc(1, 0, 0);
    n_cmp++; if (t >= 400) begin n_bad++; $display("FAIL reach_x100: ticks=%0d limit=400", t); end
    probe(100, 368, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b1) begin n_bad++; $display("FAIL px_100_368: dut=%h exp=%h", a, e); end
    probe(115, 399, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b1) begin n_bad++; $display("FAIL px_115_399: dut=%h exp=%h", a, e); end
    probe(116, 380, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b0) begin n_bad++; $display("FAIL px_116_380: dut=%h exp=%h", a, e); end
    probe(100, 367, a, e);
    n_cmp++; if (a !== e || a[0] !== (m_h(0) == 2*OH)) begin n_bad++; $display("FAIL px_100_367: dut=%h exp=%h", a, e); end
    for (t = 0; t < 40 && m_x[0] != 0; t++) cyc(1, 0, 0);
    probe(0, 399, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b1) begin n_bad++; $display("FAIL px_x0: dut=%h exp=%h", a, e); end
    cyc(1, 0, 0);
    probe(0, 399, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b0 || a[8:1] !== 8'd1) begin n_bad++; $display("FAIL remove_x0: dut=%h exp=%h", a, e); end
  endtask

  task automatic test_collision();
    logic [14:0] a, e;
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    probe(636, 399, a, e);
    n_cmp++; if (a !== e || a[13] !== 1'b1 || a[0] !== 1'b1) begin n_bad++; $display("FAIL coll_dead: dut=%h exp=%h", a, e); end
    probe(632, 399, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b0) begin n_bad++; $display("FAIL coll_frozen: dut=%h exp=%h", a, e); end
    repeat (5) cyc(1, 0, 0);
    probe(636, 399, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b1) begin n_bad++; $display("FAIL dead_ticks: dut=%h exp=%h", a, e); end
    cyc(0, 0, 1);
    probe(636, 399, a, e);
    n_cmp++; if (a !== e || a[14] !== 1'b1 || a[0] !== 1'b0) begin n_bad++; $display("FAIL dead_restart: dut=%h exp=%h", a, e); end
  endtask

  task automatic test_slots_full();
    logic [14:0] a, e;
    int t;
    cyc(0, 0, 1);
    for (t = 0; t < 1000 && !(m_act[0] && m_act[1] && m_gap <= m_speed); t++) cyc(1, 0, 0);
    n_cmp++; if (t >= 1000) begin n_bad++; $display("FAIL reach_full: ticks=%0d limit=1000", t); end
    cyc(1, 0, 0);
    probe(640, 399, a, e);
    n_cmp++; if (a !== e || a[0] !== 1'b0) begin n_bad++; $display("FAIL full_no_spawn: dut=%h exp=%h", a, e); end
    for (t = 0; t < 400 && !((m_act[0] && m_x[0] == 640) || (m_act[1] && m_x[1] == 640)); t++) cyc(1, 0, 0);
    probe(640, 399, a, e);
    n_cmp++; if (t >= 400 || a !== e || a[0] !== 1'b1) begin n_bad++; $display("FAIL reuse_spawn: dut=%h exp=%h ticks=%0d", a, e, t); end
  endtask

  task automatic test_speed_ramp();
    logic [14:0] a, e;
    int h, v;
    bit seen5 = 0;
    bit done = 0;
    int p12 = -1;
    cyc(0, 0, 1);
    for (int t = 0; t < 40000 && !done; t++) begin
      cyc(1, 0, 0);
      if ($urandom_range(1, 0) != 0) cyc(0, 0, 0);
      pick(h, v);
      probe(h, v, a, e);
      n_cmp++; if (a !== e) begin n_bad++; $display("FAIL ramp_tick%0d: dut=%h exp=%h (h=%0d v=%0d)", t, a, e, h, v); end
      if (!seen5 && m_passed >= 16) begin
        seen5 = 1;
        n_cmp++; if (a[12:9] !== 4'd5) begin n_bad++; $display("FAIL speed_step5: dut=%0d exp=5", a[12:9]); end
      end
      if (m_speed == 12 && p12 < 0) p12 = m_passed;
      if (p12 >= 0 && m_passed >= p12 + 16) begin
        done = 1;
        n_cmp++; if (a[12:9] !== 4'd12) begin n_bad++; $display("FAIL speed_sat12: dut=%0d exp=12", a[12:9]); end
      end
    end
    n_cmp++; if (!done) begin n_bad++; $display("FAIL ramp_timeout: done=%0d exp=1", done); end
  endtask

  task automatic test_random_mix();
    logic [14:0] a, e;
    int h, v, r;
    for (int t = 0; t < 800; t++) begin
      r = int'($urandom_range(99, 0));
      cyc(int'($urandom_range(1, 0)), (r < 3) ? 1 : 0, (r >= 3 && r < 6) ? 1 : 0);
      pick(h, v);
      probe(h, v, a, e);
      n_cmp++; if (a !== e) begin n_bad++; $display("FAIL mix_cyc%0d: dut=%h exp=%h (h=%0d v=%0d)", t, a, e, h, v); end
    end
  endtask

  initial begin
    bus.i_game_tick = 1'b0;
    bus.i_collision = 1'b0;
    bus.i_restart   = 1'b0;
    bus.i_hpos      = '0;
    bus.i_vpos      = '0;
    test_reset();
    test_first_spawn();
    test_pixel_bounds();
    test_collision();
    test_slots_full();
    test_speed_ramp();
    test_random_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
